// File: rtl/fmcw_downsample.sv
// Integer-factor decimator: keeps one sample in DEC and emits a registered
// divided clock (f/DEC, 50 % duty) whose rising edge sits mid-way in data_o's stable window.
module fmcw_downsample #(
    parameter int OW  = 14,
    parameter int DEC = 20,
    parameter int CW  = $clog2(DEC)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [OW-1:0] data_i,
    output logic          clk_o,
    output logic [OW-1:0] data_o
);

    localparam logic [CW-1:0] CAP_PH = CW'(DEC / 2 - 1);
    localparam logic [CW-1:0] END_PH = CW'(DEC - 1);

    generate
        if (DEC < 2 || (DEC % 2) != 0) begin : g_bad_dec
            $error("fmcw_downsample: DEC must be even and >= 2");
        end
    endgenerate

    logic [CW-1:0] ctr;

    // Capture and fall share one phase, so data_o only moves while clk_o goes low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctr    <= '0;
            clk_o  <= 1'b0;
            data_o <= '0;
        end else begin
            if (ctr == END_PH) ctr <= '0;
            else               ctr <= ctr + 1'b1;

            if (ctr == CAP_PH) begin
                data_o <= data_i;
                clk_o  <= 1'b0;
            end else if (ctr == END_PH) begin
                clk_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fmcw_downsample.sv
// Scoreboard bench for fmcw_downsample: DEC=20 and DEC=2 instances share one
// stimulus stream; expectations come from an edge-count reference model.
module tb_fmcw_downsample;

    localparam int OW = 14;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [OW-1:0] data_i;
    logic          clk20, clk2;
    logic [OW-1:0] d20, d2;

    always #5 clk = ~clk;

    fmcw_downsample #(.OW(OW), .DEC(20)) u_dut20 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .clk_o(clk20), .data_o(d20)
    );

    fmcw_downsample #(.OW(OW), .DEC(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .clk_o(clk2), .data_o(d2)
    );

    typedef struct packed {
        logic          c20;
        logic [OW-1:0] d20;
        logic          c2;
        logic [OW-1:0] d2;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_exp, mon_act;
    int            vectors = 0;
    int            miscompares = 0;
    int            n = 0;
    bit            running = 1'b1;
    logic [OW-1:0] hist [0:4095];

    // n = edges since reset release, including this one; hist[k] = sample at edge k.
    // clk_o is high in the second half of every full period after the first;
    // data_o is the sample from the latest edge k <= n with k mod dec == dec/2.
    function automatic logic [OW:0] ref_out(input int dec, input int edge_n);
        logic          c;
        logic [OW-1:0] d;
        int            k;
        c = (edge_n >= dec) && ((edge_n % dec) < dec / 2);
        if (edge_n < dec / 2) begin
            d = '0;
        end else begin
            k = edge_n - ((edge_n - dec / 2) % dec);
            d = hist[k];
        end
        return {c, d};
    endfunction

    task automatic step(input logic r, input logic [OW-1:0] d);
        logic [OW:0] a, b;
        exp_t        e;
        rst_i  = r;
        data_i = d;
        if (r) begin
            n = 0;
        end else begin
            n++;
            hist[n] = d;
        end
        a = ref_out(20, n);
        b = ref_out(2, n);
        e.c20 = a[OW];
        e.d20 = a[OW-1:0];
        e.c2  = b[OW];
        e.d2  = b[OW-1:0];
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                if (running) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_empty at %0t: no expectation queued", $time);
                end
            end else begin
                mon_exp = sb_q.pop_front();
                mon_act.c20 = clk20;
                mon_act.d20 = d20;
                mon_act.c2  = clk2;
                mon_act.d2  = d2;
                vectors++;
                if (mon_act !== mon_exp) begin
                    miscompares++;
                    $display("FAIL outputs at %0t: got clk20=%b d20=%0d clk2=%b d2=%0d, want clk20=%b d20=%0d clk2=%b d2=%0d",
                             $time, mon_act.c20, mon_act.d20, mon_act.c2, mon_act.d2,
                             mon_exp.c20, mon_exp.d20, mon_exp.c2, mon_exp.d2);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i  = 1'b1;
        data_i = '0;

        // Reset held with random data on the input.
        repeat (5) step(1'b1, OW'($urandom));

        // Ramp, then reset at edge 25 while clk_o of DEC=20 is high.
        for (int i = 1; i <= 24; i++) step(1'b0, OW'(i));
        step(1'b1, OW'(25));

        // Ramp data_i = edge number over several full periods.
        for (int i = 1; i <= 85; i++) step(1'b0, OW'(i));
        step(1'b1, '0);

        // Data wrap: 16380 captured at edge 10, 16 at edge 30.
        for (int i = 1; i <= 60; i++) step(1'b0, OW'(16370 + i));
        step(1'b1, '0);

        // Long random run with rare resets at arbitrary phases.
        for (int i = 0; i < 1000; i++)
            step(($urandom_range(0, 299) == 0), OW'($urandom));

        running = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
